// File: rtl/myo_control_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// myo_ctrl_pkg
// Shared types and helpers for the motor control sequencer.
//   seq_state_t  : sequencer FSM states
//   idx_width()  : width of a motor index for a given channel count (min 1)
//   sat_inc16()  : 16-bit increment that sticks at 0xFFFF
// ----------------------------------------------------------------------------
package myo_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        SCAN,
        ISSUE,
        WAIT_DONE,
        FINISH
    } seq_state_t;

    // A single channel still needs a one-bit index so the port exists.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Event counters saturate so that a long-running fault stays visible
    // instead of wrapping back to a harmless-looking small number.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/myo_control_sequencer_rate_tick.sv
// ----------------------------------------------------------------------------
// myo_rate_tick
// Phase-accumulator tick generator. Produces a one-cycle tick at an average
// rate of update_frequency Hz, given a clock of CLOCK_FREQ_HZ.
//   clock            : system clock
//   reset_n          : asynchronous active-low reset
//   enable           : run enable; when low the accumulator is held at 0
//   update_frequency : requested tick rate in Hz (clamped to CLOCK_FREQ_HZ)
//   tick             : registered one-cycle tick
// ----------------------------------------------------------------------------
module myo_rate_tick #(
    parameter int unsigned CLOCK_FREQ_HZ = 50000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] update_frequency,
    output logic        tick
);

    localparam logic [31:0] FREQ_32 = 32'(CLOCK_FREQ_HZ);
    localparam logic [32:0] FREQ_33 = {1'b0, FREQ_32};

    logic [32:0] acc;
    logic [32:0] increment;
    logic [32:0] sum;

    // Requests above the clock rate would need more than one tick per cycle,
    // so they are clamped to one tick per cycle. The accumulator stays below
    // CLOCK_FREQ_HZ after each update, so the sum fits in 33 bits.
    always_comb begin
        increment = '0;
        if (update_frequency > FREQ_32) begin
            increment = FREQ_33;
        end else begin
            increment = {1'b0, update_frequency};
        end
        sum = acc + increment;
    end

    // Add the step every enabled cycle; on overflow past CLOCK_FREQ_HZ emit a
    // tick and keep the remainder so the long-term rate is exact.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (!enable) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (sum >= FREQ_33) begin
            acc  <= sum - FREQ_33;
            tick <= 1'b1;
        end else begin
            acc  <= sum;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/myo_control_sequencer.sv
// ----------------------------------------------------------------------------
// myo_control_sequencer
// Time-multiplexes one shared control engine over NUMBER_OF_MOTORS channels.
// Each sweep tick walks the enabled motors in index order with one
// start/done handshake per motor, and the achieved sweep rate is measured
// over CLOCK_FREQ_HZ-cycle windows.
//   clock                   : system clock
//   reset_n                 : asynchronous active-low reset
//   enable                  : sequencer run enable
//   update_frequency        : requested sweep rate in Hz, 0 = no sweeps
//   motor_enable            : per-motor mask, latched at the start of a sweep
//   eng_start               : one-cycle engine start strobe
//   eng_motor_idx           : motor currently handed to the engine
//   eng_done                : engine completion pulse
//   sweep_done              : one-cycle pulse at the end of each sweep
//   busy                    : high while a sweep is in progress
//   actual_update_frequency : sweeps completed in the last window
//   timeout_count           : saturating count of engine timeouts
//   overrun_count           : saturating count of dropped ticks
//   timeout_flag            : sticky timeout indicator, cleared by reset
// ----------------------------------------------------------------------------
module myo_control_sequencer
    import myo_ctrl_pkg::*;
#(
    parameter int          NUMBER_OF_MOTORS = 8,
    parameter int unsigned CLOCK_FREQ_HZ    = 50000000,
    parameter int unsigned TIMEOUT_CYCLES   = 4096,
    parameter int          IDX_W            = idx_width(NUMBER_OF_MOTORS)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [31:0]                 update_frequency,
    input  logic [NUMBER_OF_MOTORS-1:0] motor_enable,
    output logic                        eng_start,
    output logic [IDX_W-1:0]            eng_motor_idx,
    input  logic                        eng_done,
    output logic                        sweep_done,
    output logic                        busy,
    output logic [31:0]                 actual_update_frequency,
    output logic [15:0]                 timeout_count,
    output logic [15:0]                 overrun_count,
    output logic                        timeout_flag
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_OF_MOTORS - 1);

    // The timer is zero in the ISSUE cycle and counts every cycle after it,
    // so the wait gives up in the cycle that would bring it to TIMEOUT_CYCLES.
    localparam logic [31:0] TIMER_LIMIT =
        (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
    localparam logic [31:0] WINDOW_LAST =
        (CLOCK_FREQ_HZ > 0) ? 32'(CLOCK_FREQ_HZ - 1) : 32'd0;

    seq_state_t                  state;
    logic [NUMBER_OF_MOTORS-1:0] mask;
    logic [IDX_W-1:0]            idx;
    logic                        pending;
    logic [31:0]                 timer;
    logic                        tick;
    logic [31:0]                 window_count;
    logic [31:0]                 sweep_count;

    myo_rate_tick #(
        .CLOCK_FREQ_HZ(CLOCK_FREQ_HZ)
    ) u_rate_tick (
        .clock           (clock),
        .reset_n         (reset_n),
        .enable          (enable),
        .update_frequency(update_frequency),
        .tick            (tick)
    );

    // Sequencer FSM with registered strobes. eng_start and sweep_done are
    // raised on the transition into ISSUE / FINISH so they are high exactly
    // during those states. A tick that arrives while busy is remembered once
    // in pending so the next sweep starts immediately; any further tick in
    // the same sweep is lost and counted as an overrun.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mask          <= '0;
            idx           <= '0;
            pending       <= 1'b0;
            timer         <= '0;
            eng_start     <= 1'b0;
            eng_motor_idx <= '0;
            sweep_done    <= 1'b0;
            busy          <= 1'b0;
            timeout_count <= '0;
            overrun_count <= '0;
            timeout_flag  <= 1'b0;
        end else begin
            eng_start  <= 1'b0;
            sweep_done <= 1'b0;

            if (!enable) begin
                pending <= 1'b0;
            end else if (tick && busy) begin
                if (pending) begin
                    overrun_count <= sat_inc16(overrun_count);
                end else begin
                    pending <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= WAIT_TICK;
                    end
                end

                WAIT_TICK: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (tick || pending) begin
                        mask    <= motor_enable;
                        idx     <= '0;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end

                SCAN: begin
                    if (!enable || (!mask[idx] && (idx == LAST_IDX))) begin
                        sweep_done <= 1'b1;
                        state      <= FINISH;
                    end else if (mask[idx]) begin
                        eng_start     <= 1'b1;
                        eng_motor_idx <= idx;
                        timer         <= '0;
                        state         <= ISSUE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                ISSUE: begin
                    timer <= timer + 32'd1;
                    state <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (eng_done || (timer >= TIMER_LIMIT)) begin
                        if (!eng_done) begin
                            timeout_count <= sat_inc16(timeout_count);
                            timeout_flag  <= 1'b1;
                        end
                        if (!enable || (idx == LAST_IDX)) begin
                            sweep_done <= 1'b1;
                            state      <= FINISH;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    state <= enable ? WAIT_TICK : IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running measurement window. At the wrap the finished window's
    // sweep count is published, and a sweep ending in the wrap cycle is
    // credited to the window that starts next.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            window_count            <= '0;
            sweep_count             <= '0;
            actual_update_frequency <= '0;
        end else if (window_count == WINDOW_LAST) begin
            window_count            <= '0;
            actual_update_frequency <= sweep_count;
            sweep_count             <= {31'd0, sweep_done};
        end else begin
            window_count <= window_count + 32'd1;
            sweep_count  <= sweep_count + {31'd0, sweep_done};
        end
    end

endmodule
